// File: rtl/irq_controller.sv
// External interrupt controller for the MIPS core: edge-latched, masked, priority-selected
// request held until CP0 ack, blocked until eret. Define IRQ_CTRL_ROTATE_PRIO_EN for rotating priority.
module irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic               i_ack,
  input  logic               i_eret,
  input  logic               i_we,
  input  logic [1:0]         i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_external_interrupt,
  output logic [ID_W-1:0]    o_irq_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_ID      = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [NUM_SRC-1:0] irq_edge;
  logic [NUM_SRC-1:0] masked_pending;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_id;
  logic               ack_taken;

  assign irq_edge       = i_irq & ~irq_q;
  assign masked_pending = pending_q & mask_q;
  assign sel_valid      = |masked_pending;
  assign ack_taken      = (state_q == ST_REQ) && i_ack;

`ifdef IRQ_CTRL_ROTATE_PRIO_EN
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [ID_W-1:0]      start_id;
  logic [2*NUM_SRC-1:0] doubled;
  logic [NUM_SRC-1:0]   rotated;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        id_sum;

  // Rotate the request vector so the search origin lands at bit 0, find the
  // lowest set bit there, then map the offset back to an absolute index.
  always_comb begin
    start_id = (last_id_q == ID_W'(NUM_SRC - 1)) ? '0 : last_id_q + ID_W'(1);
    doubled  = {masked_pending, masked_pending} >> start_id;
    rotated  = doubled[NUM_SRC-1:0];
    offset   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ID_W'(i);
    end
    id_sum = {1'b0, start_id} + {1'b0, offset};
    if (id_sum >= (ID_W + 1)'(NUM_SRC)) id_sum = id_sum - (ID_W + 1)'(NUM_SRC);
    sel_id = id_sum[ID_W-1:0];
  end

  assign last_id_d = ack_taken ? id_q : last_id_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) last_id_q <= ID_W'(NUM_SRC - 1);
    else       last_id_q <= last_id_d;
  end
`else
  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (masked_pending[i]) sel_id = ID_W'(i);
    end
  end
`endif

  // Clear paths first, edge set last: a new edge always beats W1C or ack.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (i_we && (i_addr == ADDR_MASK)) mask_d = i_wdata[NUM_SRC-1:0];
    if (i_we && (i_addr == ADDR_PENDING)) pending_d = pending_d & ~i_wdata[NUM_SRC-1:0];
    if (ack_taken) pending_d[id_q] = 1'b0;
    pending_d = pending_d | irq_edge;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          id_d    = sel_id;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (i_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= i_irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
    end
  end

  always_comb begin
    o_rdata = '0;
    unique case (i_addr)
      ADDR_MASK:    o_rdata[NUM_SRC-1:0] = mask_q;
      ADDR_PENDING: o_rdata[NUM_SRC-1:0] = pending_q;
      ADDR_ID: begin
        o_rdata[ID_W-1:0] = id_q;
        o_rdata[31]       = (state_q != ST_IDLE);
      end
      ADDR_STATUS:  o_rdata[1:0] = state_q;
      default:      o_rdata = '0;
    endcase
  end

  assign o_external_interrupt = (state_q == ST_REQ);
  assign o_irq_id             = id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a per-cycle behavioural model checked on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_irq_controller;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          ack, eret, we;
  logic [1:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ext;
  logic [2:0]    irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  irq_controller #(.NUM_SRC(N), .ID_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_ack(ack), .i_eret(eret),
    .i_we(we), .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata),
    .o_external_interrupt(ext), .o_irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state as a plain number (0 idle, 1 requesting, 2 in service).
  int       m_state = 0;
  bit [N-1:0] m_mask = '0, m_pend = '0, m_prev = '0;
  int       m_id = 0;
  int       m_last = N - 1;

  function automatic int pick(input bit [N-1:0] req, input int last);
    int start;
`ifdef IRQ_CTRL_ROTATE_PRIO_EN
    start = (last + 1) % N;
`else
    start = 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (req[(start + i) % N]) return (start + i) % N;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] nxt_pend, nxt_mask;
    int nxt_state, nxt_id, nxt_last;
    if (rst) begin
      m_state = 0; m_mask = '0; m_pend = '0; m_prev = '0; m_id = 0; m_last = N - 1;
    end else begin
      nxt_pend = m_pend; nxt_mask = m_mask;
      nxt_state = m_state; nxt_id = m_id; nxt_last = m_last;
      if (we && addr == 2'd0) nxt_mask = wdata[N-1:0];
      if (we && addr == 2'd1) nxt_pend = nxt_pend & ~wdata[N-1:0];
      if (m_state == 1 && ack) begin
        nxt_pend[m_id] = 1'b0;
        nxt_state = 2;
        nxt_last = m_id;
      end
      nxt_pend = nxt_pend | (irq & ~m_prev);
      if (m_state == 0 && (m_pend & m_mask) != 0) begin
        nxt_id = pick(m_pend & m_mask, m_last);
        nxt_state = 1;
      end
      if (m_state == 2 && eret) nxt_state = 0;
      m_pend = nxt_pend; m_mask = nxt_mask; m_prev = irq;
      m_state = nxt_state; m_id = nxt_id; m_last = nxt_last;
    end
  end

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_pend);
      2'd2:    return ((m_state != 0) ? 32'h8000_0000 : 32'h0) | 32'(m_id);
      default: return 32'(m_state);
    endcase
  endfunction

  always @(negedge clk) begin
    check("ext", 32'(ext), 32'(m_state == 1));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("rdata", rdata, model_rdata(addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; irq = '0; ack = 1'b0; eret = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    settle();
    check("reset_ext", 32'(ext), 32'd0);
    rd_check("reset_status", 2'd3, 32'h0);
    rd_check("reset_mask", 2'd0, 32'h0);

    // Single edge on source 3: request two cycles after the edge.
    wr(2'd0, 32'hFF);
    irq = 8'h08; tick(); irq = '0; tick();
    settle();
    check("src3_ext", 32'(ext), 32'd1);
    check("src3_id", 32'(irq_id), 32'd3);
    rd_check("src3_idreg", 2'd2, 32'h8000_0003);
    pulse_ack();
    settle();
    check("src3_ack_ext", 32'(ext), 32'd0);
    rd_check("src3_ack_pend", 2'd1, 32'h0);
    rd_check("src3_status_svc", 2'd3, 32'h2);
    pulse_eret();
    settle();
    rd_check("src3_status_idle", 2'd3, 32'h0);

    // Masked edge stays pending without a request until unmasked.
    wr(2'd0, 32'h00);
    irq = 8'h20; tick(); irq = '0; tick(); tick();
    settle();
    rd_check("masked_pend", 2'd1, 32'h20);
    check("masked_no_req", 32'(ext), 32'd0);
    wr(2'd0, 32'h20);
    tick();
    settle();
    check("unmask_ext", 32'(ext), 32'd1);
    check("unmask_id", 32'(irq_id), 32'd5);
    pulse_ack(); pulse_eret();

    // Simultaneous 2/6 pairs.
    wr(2'd0, 32'hFF);
    irq = 8'h44; tick(); irq = '0; tick();
    settle();
    check("pair1_id", 32'(irq_id), 32'd2);
    pulse_ack();
    eret = 1'b1; tick(); eret = 1'b0; tick();
    settle();
    check("pair1_second_id", 32'(irq_id), 32'd6);
    pulse_ack();
    eret = 1'b1; irq = 8'h44; tick(); eret = 1'b0; irq = '0; tick();
    settle();
    check("pair2_id", 32'(irq_id), 32'd2);
    pulse_ack();
    eret = 1'b1; irq = 8'h44; tick(); eret = 1'b0; irq = '0; tick();
    settle();
`ifdef IRQ_CTRL_ROTATE_PRIO_EN
    check("pair3_id", 32'(irq_id), 32'd6);
`else
    check("pair3_id", 32'(irq_id), 32'd2);
`endif
    pulse_ack();
    wr(2'd1, 32'hFF);
    pulse_eret();
    tick();

    // W1C colliding with a new edge on the same bit.
    wr(2'd0, 32'h00);
    irq = 8'h10; tick(); irq = '0; tick();
    we = 1'b1; addr = 2'd1; wdata = 32'h10; irq = 8'h10;
    tick();
    we = 1'b0; wdata = '0; irq = '0;
    settle();
    rd_check("w1c_vs_edge", 2'd1, 32'h10);
    wr(2'd1, 32'h10);
    settle();
    rd_check("w1c_clear", 2'd1, 32'h0);

    // Re-edge on the in-service source waits for eret.
    wr(2'd0, 32'h02);
    irq = 8'h02; tick(); irq = '0; tick();
    settle();
    check("svc1_id", 32'(irq_id), 32'd1);
    pulse_ack();
    irq = 8'h02; tick(); irq = '0; tick(); tick();
    settle();
    check("svc1_blocked", 32'(ext), 32'd0);
    rd_check("svc1_repend", 2'd1, 32'h02);
    pulse_eret();
    tick();
    settle();
    check("svc1_reissue_ext", 32'(ext), 32'd1);
    check("svc1_reissue_id", 32'(irq_id), 32'd1);

    // Reset while requesting, with irq[0] held high through reset.
    irq = 8'h01; rst = 1'b1;
    tick();
    settle();
    check("rst_ext", 32'(ext), 32'd0);
    rd_check("rst_status", 2'd3, 32'h0);
    rd_check("rst_mask", 2'd0, 32'h0);
    rd_check("rst_pend", 2'd1, 32'h0);
    rst = 1'b0;
    tick();
    settle();
    rd_check("post_rst_edge", 2'd1, 32'h01);
    irq = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
